debug_capture_sequencer: RTL and testbench

- Controller that sequences block writes of the packed debug bus into the per-channel debug output FIFOs. These FIFOs are read by the okBTPipeOut endpoints at 0xB0+i.
- Replaces fixed free-running capture with idle, free-run, single-shot and triggered modes, plus decimation, abort, block counting and missed-trigger status.
- Sits between the debug_wireout sources and the FIFO write ports, in the clk domain.
- Every block is exactly BLOCK_LEN words, so host framing is unchanged.

---
 rtl/debug_capture_sequencer_if.sv | 28 ++
 rtl/debug_capture_sequencer.sv | 143 ++++++++++++++
 tb/tb_debug_capture_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/debug_capture_sequencer_if.sv
// rtl/debug_capture_sequencer_if.sv - control, sample and FIFO-write bundle for the capture sequencer
interface debug_capture_sequencer_if #(
  parameter int SIZE    = 1,
  parameter int USEDW_W = 13
);
  logic [1:0]              ctrl_mode;
  logic                    ctrl_arm;
  logic                    ctrl_abort;
  logic                    trigger;
  logic [7:0]              decim;
  logic [32*SIZE-1:0]      debug_wireout;
  logic [USEDW_W*SIZE-1:0] fifo_wrusedw;
  logic                    buffer_wrreq;
  logic [32*SIZE-1:0]      buffer_data;
  logic                    busy;
  logic [15:0]             block_count;
  logic                    trig_missed;

  modport master (
    output ctrl_mode, ctrl_arm, ctrl_abort, trigger, decim, debug_wireout, fifo_wrusedw,
    input  buffer_wrreq, buffer_data, busy, block_count, trig_missed
  );

  modport slave (
    input  ctrl_mode, ctrl_arm, ctrl_abort, trigger, decim, debug_wireout, fifo_wrusedw,
    output buffer_wrreq, buffer_data, busy, block_count, trig_missed
  );
endinterface

// File: rtl/debug_capture_sequencer.sv
// rtl/debug_capture_sequencer.sv - sequences fixed-length marker-terminated blocks of debug samples into FIFOs
module debug_capture_sequencer #(
  parameter int          SIZE       = 1,
  parameter int          BLOCK_LEN  = 1024,
  parameter int          FIFO_DEPTH = 4096,
  parameter int          USEDW_W    = 13,
  parameter logic [31:0] MARKER     = 32'hFFFF_FFFF
) (
  input logic clk,
  input logic reset,
  debug_capture_sequencer_if.slave bus
);
  localparam int unsigned SPACE_MAX = FIFO_DEPTH - BLOCK_LEN;
  localparam int          CNT_W     = $clog2(BLOCK_LEN);
  localparam logic [CNT_W-1:0] LAST_SMP = CNT_W'(BLOCK_LEN - 2);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_SPACE, S_WAIT_TRIG, S_CAPTURE, S_MARKER
  } state_t;

  state_t             r_state, w_state;
  logic [1:0]         r_mode, w_mode;
  logic [7:0]         r_decim, w_decim;
  logic [7:0]         r_dec_cnt, w_dec_cnt;
  logic [CNT_W-1:0]   r_smp_cnt, w_smp_cnt;
  logic               r_abort_pend, w_abort_pend;
  logic               r_trig, r_trig_d;
  logic               r_wrreq, w_wrreq;
  logic [32*SIZE-1:0] r_data, w_data;
  logic [15:0]        r_blk_cnt, w_blk_cnt;
  logic               r_trig_missed, w_trig_missed;
  logic               w_space;
  logic               w_trig_edge;

  // Edge is taken on the registered trigger so the path from the pin is a single flop.
  assign w_trig_edge = r_trig & ~r_trig_d;

  always_comb begin
    w_space = 1'b1;
    for (int i = 0; i < SIZE; i++) begin
      if (32'(bus.fifo_wrusedw[i*USEDW_W +: USEDW_W]) > SPACE_MAX) w_space = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_mode        <= 2'd0;
      r_decim       <= 8'd0;
      r_dec_cnt     <= 8'd0;
      r_smp_cnt     <= '0;
      r_abort_pend  <= 1'b0;
      r_trig        <= 1'b0;
      r_trig_d      <= 1'b0;
      r_wrreq       <= 1'b0;
      r_data        <= '0;
      r_blk_cnt     <= 16'd0;
      r_trig_missed <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_mode        <= w_mode;
      r_decim       <= w_decim;
      r_dec_cnt     <= w_dec_cnt;
      r_smp_cnt     <= w_smp_cnt;
      r_abort_pend  <= w_abort_pend;
      r_trig        <= bus.trigger;
      r_trig_d      <= r_trig;
      r_wrreq       <= w_wrreq;
      r_data        <= w_data;
      r_blk_cnt     <= w_blk_cnt;
      r_trig_missed <= w_trig_missed;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_mode        = r_mode;
    w_decim       = r_decim;
    w_dec_cnt     = r_dec_cnt;
    w_smp_cnt     = r_smp_cnt;
    w_abort_pend  = r_abort_pend;
    w_wrreq       = 1'b0;
    w_data        = r_data;
    w_blk_cnt     = r_blk_cnt;
    w_trig_missed = r_trig_missed;

    if (w_trig_edge && r_mode == 2'd3 && r_state != S_WAIT_TRIG) w_trig_missed = 1'b1;

    case (r_state)
      S_IDLE: begin
        w_abort_pend = 1'b0;
        if (bus.ctrl_arm && bus.ctrl_mode != 2'd0 && !bus.ctrl_abort) begin
          w_mode        = bus.ctrl_mode;
          w_decim       = bus.decim;
          w_trig_missed = 1'b0;
          w_state       = S_WAIT_SPACE;
        end
      end
      S_WAIT_SPACE: begin
        w_dec_cnt = 8'd0;
        w_smp_cnt = '0;
        if (bus.ctrl_abort) w_state = S_IDLE;
        else if (w_space) w_state = (r_mode == 2'd3) ? S_WAIT_TRIG : S_CAPTURE;
      end
      S_WAIT_TRIG: begin
        w_dec_cnt = 8'd0;
        w_smp_cnt = '0;
        if (bus.ctrl_abort) w_state = S_IDLE;
        else if (w_trig_edge) w_state = S_CAPTURE;
      end
      S_CAPTURE: begin
        if (bus.ctrl_abort) w_abort_pend = 1'b1;
        if (r_dec_cnt == 8'd0) begin
          w_wrreq   = 1'b1;
          w_data    = bus.debug_wireout;
          w_dec_cnt = r_decim;
          w_smp_cnt = r_smp_cnt + 1'b1;
          if (r_smp_cnt == LAST_SMP) w_state = S_MARKER;
        end else begin
          w_dec_cnt = r_dec_cnt - 8'd1;
        end
      end
      S_MARKER: begin
        w_wrreq   = 1'b1;
        w_data    = {SIZE{MARKER}};
        w_blk_cnt = r_blk_cnt + 16'd1;
        if (r_abort_pend || bus.ctrl_abort || r_mode == 2'd2) begin
          w_abort_pend = 1'b0;
          w_state      = S_IDLE;
        end else begin
          w_state = S_WAIT_SPACE;
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign bus.buffer_wrreq = r_wrreq;
  assign bus.buffer_data  = r_data;
  assign bus.busy         = (r_state != S_IDLE);
  assign bus.block_count  = r_blk_cnt;
  assign bus.trig_missed  = r_trig_missed;
endmodule

// File: tb/tb_debug_capture_sequencer.sv
// tb/tb_debug_capture_sequencer.sv - directed vector and sequence bench for debug_capture_sequencer
module tb_debug_capture_sequencer;
  localparam logic [31:0] MARKER = 32'hFFFF_FFFF;

  logic clk;
  logic reset;

  debug_capture_sequencer_if #(.SIZE(1), .USEDW_W(13)) bus ();
  debug_capture_sequencer_if #(.SIZE(2), .USEDW_W(13)) bus2 ();

  debug_capture_sequencer #(
    .SIZE(1), .BLOCK_LEN(16), .FIFO_DEPTH(4096), .USEDW_W(13), .MARKER(MARKER)
  ) u_dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  debug_capture_sequencer #(
    .SIZE(2), .BLOCK_LEN(16), .FIFO_DEPTH(4096), .USEDW_W(13), .MARKER(MARKER)
  ) u_dut2 (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [1:0] mode;
    logic [7:0] decim;
    logic       abort;
    int         exp_wr;
    int         exp_gap;
    int         exp_blk;
  } vec_t;

  vec_t vecs[6];

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_cnt, wr2_cnt, n_smp, prev_cyc, min_gap, max_gap, marker_gap;
  int exp_blocks = 0;
  logic [31:0] last_data;
  logic [31:0] dw_val = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; wr2_cnt = 0; n_smp = 0; prev_cyc = 0;
    min_gap = 1000; max_gap = 0; marker_gap = 0; last_data = 32'd0;
  endtask

  // Advance one clock; sample outputs at the falling edge. dw_val is what the DUT saw at the rising edge.
  task automatic step();
    dw_val = dw_val + 32'd1;
    bus.debug_wireout  = dw_val;
    bus2.debug_wireout = {dw_val, ~dw_val};
    @(negedge clk);
    cyc++;
    if (bus2.buffer_wrreq) wr2_cnt++;
    if (bus.buffer_wrreq) begin
      wr_cnt++;
      last_data = bus.buffer_data;
      if (bus.buffer_data == MARKER) begin
        marker_gap = cyc - prev_cyc;
      end else begin
        chk("sample_data", bus.buffer_data, dw_val);
        if (n_smp > 0) begin
          if (cyc - prev_cyc < min_gap) min_gap = cyc - prev_cyc;
          if (cyc - prev_cyc > max_gap) max_gap = cyc - prev_cyc;
        end
        n_smp++;
      end
      prev_cyc = cyc;
    end
  endtask

  task automatic arm(input logic [1:0] mode, input logic [7:0] decim, input logic abort);
    bus.ctrl_mode  = mode;
    bus.decim      = decim;
    bus.ctrl_arm   = 1'b1;
    bus.ctrl_abort = abort;
    step();
    bus.ctrl_arm   = 1'b0;
    bus.ctrl_abort = 1'b0;
  endtask

  task automatic pulse_abort();
    bus.ctrl_abort = 1'b1;
    step();
    bus.ctrl_abort = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 80 && bus.busy; k++) step();
    chk(name, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{mode: 2'd0, decim: 8'd0, abort: 1'b0, exp_wr: 0,  exp_gap: 0, exp_blk: 0};
    vecs[1] = '{mode: 2'd2, decim: 8'd0, abort: 1'b0, exp_wr: 16, exp_gap: 1, exp_blk: 1};
    vecs[2] = '{mode: 2'd2, decim: 8'd2, abort: 1'b0, exp_wr: 16, exp_gap: 3, exp_blk: 1};
    vecs[3] = '{mode: 2'd2, decim: 8'd0, abort: 1'b1, exp_wr: 0,  exp_gap: 0, exp_blk: 0};
    vecs[4] = '{mode: 2'd2, decim: 8'd5, abort: 1'b0, exp_wr: 16, exp_gap: 6, exp_blk: 1};
    vecs[5] = '{mode: 2'd1, decim: 8'd1, abort: 1'b1, exp_wr: 0,  exp_gap: 0, exp_blk: 0};

    reset = 1'b0;
    bus.ctrl_mode = 2'd0; bus.ctrl_arm = 1'b0; bus.ctrl_abort = 1'b0;
    bus.trigger = 1'b0; bus.decim = 8'd0; bus.fifo_wrusedw = '0;
    bus2.ctrl_mode = 2'd0; bus2.ctrl_arm = 1'b0; bus2.ctrl_abort = 1'b0;
    bus2.trigger = 1'b0; bus2.decim = 8'd0; bus2.fifo_wrusedw = '0;
    clear_mon();
    step(); step();
    reset = 1'b1;
    step();
    chk("rst_wrreq", 32'(bus.buffer_wrreq), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_block_count", 32'(bus.block_count), 32'd0);
    chk("rst_trig_missed", 32'(bus.trig_missed), 32'd0);

    for (int i = 0; i < 6; i++) begin
      clear_mon();
      arm(vecs[i].mode, vecs[i].decim, vecs[i].abort);
      for (int k = 0; k < 150; k++) step();
      exp_blocks += vecs[i].exp_blk;
      chk($sformatf("vec%0d_writes", i), wr_cnt, vecs[i].exp_wr);
      chk($sformatf("vec%0d_blocks", i), 32'(bus.block_count), exp_blocks);
      chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'd0);
      if (vecs[i].exp_wr > 0) begin
        chk($sformatf("vec%0d_min_gap", i), min_gap, vecs[i].exp_gap);
        chk($sformatf("vec%0d_max_gap", i), max_gap, vecs[i].exp_gap);
        chk($sformatf("vec%0d_marker_gap", i), marker_gap, 32'd1);
        chk($sformatf("vec%0d_marker", i), last_data, MARKER);
      end
    end

    // Free-run: back-to-back block, next block follows, abort mid second block completes it.
    clear_mon();
    arm(2'd1, 8'd0, 1'b0);
    for (int k = 0; k < 60 && wr_cnt < 16; k++) step();
    exp_blocks++;
    chk("free_writes", wr_cnt, 32'd16);
    chk("free_min_gap", min_gap, 32'd1);
    chk("free_max_gap", max_gap, 32'd1);
    chk("free_marker", last_data, MARKER);
    chk("free_blocks", 32'(bus.block_count), exp_blocks);
    chk("free_busy", 32'(bus.busy), 32'd1);
    for (int k = 0; k < 6 && wr_cnt < 17; k++) step();
    chk("free_next_block", wr_cnt, 32'd17);
    pulse_abort();
    wait_idle("free_abort_idle");
    exp_blocks++;
    chk("free_abort_writes", wr_cnt, 32'd32);
    chk("free_abort_marker", last_data, MARKER);
    chk("free_abort_blocks", 32'(bus.block_count), exp_blocks);

    // Triggered mode latency, missed trigger during capture, return to WAIT_TRIG.
    clear_mon();
    arm(2'd3, 8'd0, 1'b0);
    step(); step(); step();
    chk("trig_wait_busy", 32'(bus.busy), 32'd1);
    chk("trig_wait_nowrite", wr_cnt, 32'd0);
    bus.trigger = 1'b1;
    step();
    chk("trig_lat_n", 32'(bus.buffer_wrreq), 32'd0);
    step();
    chk("trig_lat_n1", 32'(bus.buffer_wrreq), 32'd0);
    step();
    chk("trig_lat_n2_wrreq", 32'(bus.buffer_wrreq), 32'd1);
    chk("trig_lat_n2_data", bus.buffer_data, dw_val);
    chk("trig_missed_pre", 32'(bus.trig_missed), 32'd0);
    bus.trigger = 1'b0;
    step();
    bus.trigger = 1'b1;
    step(); step();
    chk("trig_missed_set", 32'(bus.trig_missed), 32'd1);
    bus.trigger = 1'b0;
    for (int k = 0; k < 40 && wr_cnt < 16; k++) step();
    exp_blocks++;
    chk("trig_writes", wr_cnt, 32'd16);
    chk("trig_marker", last_data, MARKER);
    chk("trig_blocks", 32'(bus.block_count), exp_blocks);
    for (int k = 0; k < 30; k++) step();
    chk("trig_rewait_nowrite", wr_cnt, 32'd16);
    chk("trig_rewait_busy", 32'(bus.busy), 32'd1);
    pulse_abort();
    chk("trig_abort_idle", 32'(bus.busy), 32'd0);

    // Abort at the fifth sample still completes the block; the arm clears trig_missed.
    clear_mon();
    arm(2'd1, 8'd0, 1'b0);
    chk("arm_clears_missed", 32'(bus.trig_missed), 32'd0);
    for (int k = 0; k < 20 && wr_cnt < 5; k++) step();
    pulse_abort();
    wait_idle("abort5_idle");
    exp_blocks++;
    chk("abort5_writes", wr_cnt, 32'd16);
    chk("abort5_marker", last_data, MARKER);
    chk("abort5_blocks", 32'(bus.block_count), exp_blocks);

    // Space gating on the single-channel instance.
    clear_mon();
    bus.fifo_wrusedw = 13'd4081;
    arm(2'd1, 8'd0, 1'b0);
    for (int k = 0; k < 100; k++) step();
    chk("space_hold_writes", wr_cnt, 32'd0);
    chk("space_hold_busy", 32'(bus.busy), 32'd1);
    bus.fifo_wrusedw = 13'd4080;
    step(); step();
    chk("space_start", wr_cnt, 32'd1);
    pulse_abort();
    wait_idle("space_abort_idle");
    exp_blocks++;
    chk("space_block_writes", wr_cnt, 32'd16);
    chk("space_blocks", 32'(bus.block_count), exp_blocks);

    clear_mon();
    bus.fifo_wrusedw = 13'd4081;
    arm(2'd1, 8'd0, 1'b0);
    step(); step(); step();
    pulse_abort();
    chk("wspace_abort_idle", 32'(bus.busy), 32'd0);
    for (int k = 0; k < 20; k++) step();
    chk("wspace_abort_nowrite", wr_cnt, 32'd0);
    bus.fifo_wrusedw = '0;

    // Two channels, only channel 1 short of space.
    clear_mon();
    bus2.fifo_wrusedw = {13'd4081, 13'd0};
    bus2.ctrl_mode = 2'd1;
    bus2.ctrl_arm = 1'b1;
    step();
    bus2.ctrl_arm = 1'b0;
    for (int k = 0; k < 100; k++) step();
    chk("ch1_hold_writes", wr2_cnt, 32'd0);
    bus2.fifo_wrusedw = {13'd4080, 13'd0};
    step(); step();
    chk("ch1_start", wr2_cnt, 32'd1);
    bus2.ctrl_abort = 1'b1;
    step();
    bus2.ctrl_abort = 1'b0;
    for (int k = 0; k < 60 && bus2.busy; k++) step();
    chk("ch1_idle", 32'(bus2.busy), 32'd0);
    chk("ch1_writes", wr2_cnt, 32'd16);

    // Asynchronous reset in the middle of a triggered capture with trig_missed set.
    clear_mon();
    arm(2'd3, 8'd0, 1'b0);
    step(); step(); step();
    bus.trigger = 1'b1;
    step(); step(); step();
    bus.trigger = 1'b0;
    step();
    bus.trigger = 1'b1;
    step(); step();
    bus.trigger = 1'b0;
    chk("pre_rst_missed", 32'(bus.trig_missed), 32'd1);
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_wrreq", 32'(bus.buffer_wrreq), 32'd0);
    chk("async_rst_busy", 32'(bus.busy), 32'd0);
    chk("async_rst_block_count", 32'(bus.block_count), 32'd0);
    chk("async_rst_trig_missed", 32'(bus.trig_missed), 32'd0);
    step(); step();
    reset = 1'b1;
    clear_mon();
    for (int k = 0; k < 20; k++) step();
    chk("post_rst_nowrite", wr_cnt, 32'd0);
    chk("post_rst_busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
